// File: rtl/prince_sbox_layer_driver_pkg.sv
// Shared types and constants for the PRINCE S-box layer sequencer.
// Holds the FSM state type, share geometry and nibble index helper.
package prince_sbox_layer_driver_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned NB_W        = 2 * NIBBLE_W;
  localparam int unsigned DEF_NIBBLES = 16;
  localparam int unsigned DEF_R_WIDTH = 108;

  // Index of the neighbouring nibble, wrapping the last one back to nibble 0.
  function automatic int unsigned next_nibble(input int unsigned k, input int unsigned n);
    return (k + 1 == n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/prince_sbox_layer_driver_if.sv
// Handshake and S-box share bundle of the PRINCE S-box layer sequencer.
// master = the sequencer, slave = round datapath / S-box / result consumer side.
interface prince_sbox_layer_driver_if
  import prince_sbox_layer_driver_pkg::*;
#(
  parameter int unsigned NIBBLES = DEF_NIBBLES,
  parameter int unsigned R_WIDTH = DEF_R_WIDTH
);
  localparam int unsigned SW = NIBBLE_W * NIBBLES;

  logic                in_valid_i;
  logic                in_ready_o;
  logic [SW-1:0]       in_s1_i;
  logic [SW-1:0]       in_s2_i;
  logic [SW-1:0]       in_s3_i;
  logic [R_WIDTH-1:0]  rnd_i;
  logic                rnd_valid_i;
  logic                rnd_ready_o;
  logic [NIBBLE_W-1:0] sbox_in1_o;
  logic [NIBBLE_W-1:0] sbox_in2_o;
  logic [NIBBLE_W-1:0] sbox_in3_o;
  logic [R_WIDTH-1:0]  sbox_r_o;
  logic [NB_W-1:0]     sbox_nb_o;
  logic [NIBBLE_W-1:0] sbox_out1_i;
  logic [NIBBLE_W-1:0] sbox_out2_i;
  logic [NIBBLE_W-1:0] sbox_out3_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [SW-1:0]       out_s1_o;
  logic [SW-1:0]       out_s2_o;
  logic [SW-1:0]       out_s3_o;
  logic                busy_o;

  modport master (
    input  in_valid_i, in_s1_i, in_s2_i, in_s3_i, rnd_i, rnd_valid_i,
           sbox_out1_i, sbox_out2_i, sbox_out3_i, out_ready_i,
    output in_ready_o, rnd_ready_o, sbox_in1_o, sbox_in2_o, sbox_in3_o, sbox_r_o,
           sbox_nb_o, out_valid_o, out_s1_o, out_s2_o, out_s3_o, busy_o
  );

  modport slave (
    output in_valid_i, in_s1_i, in_s2_i, in_s3_i, rnd_i, rnd_valid_i,
           sbox_out1_i, sbox_out2_i, sbox_out3_i, out_ready_i,
    input  in_ready_o, rnd_ready_o, sbox_in1_o, sbox_in2_o, sbox_in3_o, sbox_r_o,
           sbox_nb_o, out_valid_o, out_s1_o, out_s2_o, out_s3_o, busy_o
  );

endinterface

// File: rtl/prince_valid_pipe.sv
// Strobe delay line matching the external S-box latency.
// The tail marks the cycle in which S-box outputs belong to an issued nibble.
module prince_valid_pipe #(
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic clk,
  input  logic rst_i,
  input  logic strobe,
  output logic tail
);

  logic [SBOX_LAT-1:0] pipe_q;

  generate
    if (SBOX_LAT == 1) begin : g_one
      always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) pipe_q <= '0;
        else       pipe_q <= strobe;
      end
    end else begin : g_deep
      always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) pipe_q <= '0;
        else       pipe_q <= {pipe_q[SBOX_LAT-2:0], strobe};
      end
    end
  endgenerate

  assign tail = pipe_q[SBOX_LAT-1];

endmodule

// File: rtl/prince_sbox_layer_driver.sv
// Streams a 3-share PRINCE state through one external masked 4-bit S-box,
// one nibble per randomness strobe, and collects the shares into a result.
module prince_sbox_layer_driver
  import prince_sbox_layer_driver_pkg::*;
#(
  parameter int unsigned NIBBLES  = DEF_NIBBLES,
  parameter int unsigned SBOX_LAT = 1,
  parameter int unsigned R_WIDTH  = DEF_R_WIDTH
) (
  input logic                         clk,
  input logic                         rst_i,
  prince_sbox_layer_driver_if.master  bus
);

  localparam int unsigned SW = NIBBLE_W * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES + 1);
  localparam int unsigned IW = $clog2(NIBBLES);

  state_e              state_q, state_d;
  logic [CW-1:0]       issue_q, issue_d, cap_q, cap_d;
  logic [SW-1:0]       s1_q, s2_q, s3_q;
  logic [SW-1:0]       res1_q, res2_q, res3_q;
  logic [NIBBLE_W-1:0] hold1_q, hold2_q, hold3_q;
  logic [R_WIDTH-1:0]  hold_r_q;
  logic [NB_W-1:0]     hold_nb_q;

  logic                accept, strobe, tail, cap_done;
  logic [IW-1:0]       issue_idx, nb_idx, cap_idx;
  logic [NIBBLE_W-1:0] cur1, cur2, cur3;
  logic [NB_W-1:0]     cur_nb;

  assign issue_idx = issue_q[IW-1:0];
  assign cap_idx   = cap_q[IW-1:0];
  assign nb_idx    = IW'(next_nibble(32'(issue_idx), NIBBLES));

  assign accept = (state_q == StIdle) && bus.in_valid_i;
  assign strobe = (state_q == StRun) && bus.rnd_valid_i;

  assign cur1   = s1_q[issue_idx*NIBBLE_W +: NIBBLE_W];
  assign cur2   = s2_q[issue_idx*NIBBLE_W +: NIBBLE_W];
  assign cur3   = s3_q[issue_idx*NIBBLE_W +: NIBBLE_W];
  assign cur_nb = {s2_q[nb_idx*NIBBLE_W +: NIBBLE_W], s1_q[nb_idx*NIBBLE_W +: NIBBLE_W]};

  // Look ahead one capture so out_valid rises the cycle after the last capture.
  assign cap_done = (cap_q == CW'(NIBBLES)) || (tail && (cap_q == CW'(NIBBLES - 1)));

  prince_valid_pipe #(
    .SBOX_LAT(SBOX_LAT)
  ) u_valid_pipe (
    .clk   (clk),
    .rst_i (rst_i),
    .strobe(strobe),
    .tail  (tail)
  );

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    cap_d   = tail ? cap_q + 1'b1 : cap_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          issue_d = '0;
          cap_d   = '0;
        end
      end
      StRun: begin
        if (strobe) begin
          issue_d = issue_q + 1'b1;
          if (issue_q == CW'(NIBBLES - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (cap_done) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      issue_q   <= '0;
      cap_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
      res3_q    <= '0;
      hold1_q   <= '0;
      hold2_q   <= '0;
      hold3_q   <= '0;
      hold_r_q  <= '0;
      hold_nb_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      cap_q   <= cap_d;
      if (accept) begin
        s1_q <= bus.in_s1_i;
        s2_q <= bus.in_s2_i;
        s3_q <= bus.in_s3_i;
      end
      // S-box inputs keep their last issued value through stall bubbles.
      if (strobe) begin
        hold1_q   <= cur1;
        hold2_q   <= cur2;
        hold3_q   <= cur3;
        hold_r_q  <= bus.rnd_i;
        hold_nb_q <= cur_nb;
      end
      if (tail) begin
        res1_q[cap_idx*NIBBLE_W +: NIBBLE_W] <= bus.sbox_out1_i;
        res2_q[cap_idx*NIBBLE_W +: NIBBLE_W] <= bus.sbox_out2_i;
        res3_q[cap_idx*NIBBLE_W +: NIBBLE_W] <= bus.sbox_out3_i;
      end
    end
  end

  always_comb begin
    bus.in_ready_o  = (state_q == StIdle);
    bus.busy_o      = (state_q != StIdle);
    bus.out_valid_o = (state_q == StDone);
    bus.rnd_ready_o = strobe;
    bus.sbox_in1_o  = strobe ? cur1 : hold1_q;
    bus.sbox_in2_o  = strobe ? cur2 : hold2_q;
    bus.sbox_in3_o  = strobe ? cur3 : hold3_q;
    bus.sbox_r_o    = strobe ? bus.rnd_i : hold_r_q;
    bus.sbox_nb_o   = strobe ? cur_nb : hold_nb_q;
    bus.out_s1_o    = res1_q;
    bus.out_s2_o    = res2_q;
    bus.out_s3_o    = res3_q;
  end

endmodule

// File: tb/tb_prince_sbox_layer_driver.sv
// Directed bench for the PRINCE S-box layer sequencer with a behavioural
// 3-share inverse S-box and a result scoreboard.
module tb_prince_sbox_layer_driver;

  localparam int unsigned NIB = 16;
  localparam int unsigned RW  = 108;
  localparam logic [63:0] PLAIN     = 64'h0123456789ABCDEF;
  localparam logic [63:0] INV_PLAIN = 64'hB732FD89A6405EC1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prince_sbox_layer_driver_if #(.NIBBLES(NIB), .R_WIDTH(RW)) bus ();

  prince_sbox_layer_driver #(
    .NIBBLES (NIB),
    .SBOX_LAT(1),
    .R_WIDTH (RW)
  ) dut (
    .clk  (clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  logic [3:0] inv_tab [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                               4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  function automatic logic [63:0] inv_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_tab[x[4*i +: 4]];
    return y;
  endfunction

  task automatic chk_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Masked inverse S-box model: output shares XOR to inv(x), one-cycle latency.
  always @(posedge clk) begin
    bus.sbox_out1_i <= inv_tab[bus.sbox_in1_o ^ bus.sbox_in2_o ^ bus.sbox_in3_o]
                       ^ bus.sbox_r_o[3:0] ^ bus.sbox_nb_o[3:0];
    bus.sbox_out2_i <= bus.sbox_r_o[7:4];
    bus.sbox_out3_i <= bus.sbox_r_o[7:4] ^ bus.sbox_r_o[3:0] ^ bus.sbox_nb_o[3:0];
  end

  // Scoreboard: compare each handshaken result with the oldest pushed expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
      chk_b("sb_nonempty", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0)
        chk_v("sb_result", 128'(bus.out_s1_o ^ bus.out_s2_o ^ bus.out_s3_o),
              128'(sb_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge with the DUT idle; returns at the falling
  // edge of the first out_valid cycle, or with rst asserted when aborting.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input int st_a, input int st_b, input int abort_at,
                        input int exp_lat, input string tag);
    int issues = 0;
    int lat = -1;
    int k;
    logic [3:0] last1 = '0;
    bus.in_valid_i = 1'b1;
    bus.in_s1_i = a;
    bus.in_s2_i = b;
    bus.in_s3_i = c;
    @(negedge clk);
    chk_b({tag, "_in_ready"}, bus.in_ready_o, 1'b1);
    @(posedge clk);
    sb_q.push_back(inv_layer(a ^ b ^ c));
    #1;
    bus.in_valid_i = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      bus.rnd_valid_i = (n != st_a) && (n != st_b);
      bus.rnd_i = RW'({$urandom(), $urandom(), $urandom(), $urandom()});
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        chk_v({tag, "_rst_sbox_in1"}, 128'(bus.sbox_in1_o), 128'(4'h0));
        chk_v({tag, "_rst_sbox_r"}, 128'(bus.sbox_r_o), 128'(0));
        chk_v({tag, "_rst_sbox_nb"}, 128'(bus.sbox_nb_o), 128'(8'h0));
        chk_b({tag, "_rst_rnd_ready"}, bus.rnd_ready_o, 1'b0);
        chk_b({tag, "_rst_busy"}, bus.busy_o, 1'b0);
        chk_b({tag, "_rst_out_valid"}, bus.out_valid_o, 1'b0);
        chk_v({tag, "_rst_out_s"}, 128'(bus.out_s1_o | bus.out_s2_o | bus.out_s3_o), 128'(0));
        sb_q.delete();
        return;
      end
      @(negedge clk);
      if (bus.rnd_ready_o === 1'b1) begin
        if (issues < 16) begin
          k = (issues + 1) % 16;
          chk_v({tag, "_sbox_in1"}, 128'(bus.sbox_in1_o), 128'(a[4*issues +: 4]));
          chk_v({tag, "_sbox_in3"}, 128'(bus.sbox_in3_o), 128'(c[4*issues +: 4]));
          chk_v({tag, "_sbox_nb"}, 128'(bus.sbox_nb_o), 128'({b[4*k +: 4], a[4*k +: 4]}));
          chk_v({tag, "_sbox_r"}, 128'(bus.sbox_r_o), 128'(bus.rnd_i));
          last1 = a[4*issues +: 4];
        end
        issues++;
      end else if (issues > 0 && issues < 16) begin
        chk_v({tag, "_stall_hold"}, 128'(bus.sbox_in1_o), 128'(last1));
      end
      if (bus.out_valid_o === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk_i({tag, "_latency"}, lat, exp_lat);
    chk_i({tag, "_rnd_pulses"}, issues, 16);
  endtask

  initial begin
    logic [63:0] b, c, o1, o2, o3;
    int seen;
    rst = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_s1_i     = '0;
    bus.in_s2_i     = '0;
    bus.in_s3_i     = '0;
    bus.rnd_i       = '0;
    bus.rnd_valid_i = 1'b1;
    bus.out_ready_i = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_b("reset_out_valid", bus.out_valid_o, 1'b0);
    chk_b("reset_rnd_ready", bus.rnd_ready_o, 1'b0);
    chk_b("reset_busy", bus.busy_o, 1'b0);
    chk_v("reset_sbox_in", 128'({bus.sbox_in1_o, bus.sbox_in2_o, bus.sbox_in3_o}), 128'(0));
    chk_v("reset_out_s1", 128'(bus.out_s1_o), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk_b("reset_in_ready", bus.in_ready_o, 1'b1);
    @(posedge clk);
    #1;

    // Unmasked plaintext, randomness always available.
    run_op(PLAIN, 64'h0, 64'h0, 0, 0, 0, 18, "t1");
    chk_v("t1_value", 128'(bus.out_s1_o ^ bus.out_s2_o ^ bus.out_s3_o), 128'(INV_PLAIN));
    @(posedge clk);
    #1;

    // Randomly masked plaintext.
    for (int i = 0; i < 2; i++) begin
      b = {$urandom(), $urandom()};
      c = {$urandom(), $urandom()};
      run_op(PLAIN ^ b ^ c, b, c, 0, 0, 0, 18, "t2");
      chk_v("t2_value", 128'(bus.out_s1_o ^ bus.out_s2_o ^ bus.out_s3_o), 128'(INV_PLAIN));
      @(posedge clk);
      #1;
    end

    // Randomness withheld on issue cycles 3 and 9.
    b = {$urandom(), $urandom()};
    c = {$urandom(), $urandom()};
    run_op(PLAIN ^ b ^ c, b, c, 3, 9, 0, 20, "t3");
    chk_v("t3_value", 128'(bus.out_s1_o ^ bus.out_s2_o ^ bus.out_s3_o), 128'(INV_PLAIN));
    @(posedge clk);
    #1;

    // Consumer back-pressure in DONE while a second input waits.
    bus.out_ready_i = 1'b0;
    b = {$urandom(), $urandom()};
    c = {$urandom(), $urandom()};
    run_op(PLAIN ^ b ^ c, b, c, 0, 0, 0, 18, "t4");
    o1 = bus.out_s1_o;
    o2 = bus.out_s2_o;
    o3 = bus.out_s3_o;
    b = {$urandom(), $urandom()};
    c = {$urandom(), $urandom()};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b1;
      bus.in_s1_i = b ^ c;
      bus.in_s2_i = b;
      bus.in_s3_i = c;
      @(negedge clk);
      chk_b("t4_hold_valid", bus.out_valid_o, 1'b1);
      chk_b("t4_hold_in_ready", bus.in_ready_o, 1'b0);
      chk_v("t4_hold_s1", 128'(bus.out_s1_o), 128'(o1));
      chk_v("t4_hold_s23", 128'({bus.out_s2_o, bus.out_s3_o}), 128'({o2, o3}));
    end
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk_b("t4_handshake_in_ready", bus.in_ready_o, 1'b0);
    chk_b("t4_handshake_busy", bus.busy_o, 1'b1);
    @(posedge clk);
    #1;
    run_op(b ^ c, b, c, 0, 0, 0, 18, "t4b");
    chk_v("t4b_value", 128'(bus.out_s1_o ^ bus.out_s2_o ^ bus.out_s3_o),
          128'(64'hBBBBBBBBBBBBBBBB));
    @(posedge clk);
    #1;

    // Asynchronous reset on issue cycle 7, then a fresh operation.
    b = {$urandom(), $urandom()};
    c = {$urandom(), $urandom()};
    run_op(PLAIN ^ b ^ c, b, c, 0, 0, 7, 0, "t5");
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b0) seen++;
    end
    chk_i("t5_no_out_valid", seen, 0);
    @(posedge clk);
    #1;
    run_op(PLAIN ^ b ^ c, b, c, 0, 0, 0, 18, "t5b");
    chk_v("t5b_value", 128'(bus.out_s1_o ^ bus.out_s2_o ^ bus.out_s3_o), 128'(INV_PLAIN));
    @(posedge clk);
    #1;

    // Back-to-back all-zero and all-one states.
    b = {$urandom(), $urandom()};
    c = {$urandom(), $urandom()};
    run_op(b ^ c, b, c, 0, 0, 0, 18, "t6a");
    chk_v("t6a_value", 128'(bus.out_s1_o ^ bus.out_s2_o ^ bus.out_s3_o),
          128'(64'hBBBBBBBBBBBBBBBB));
    @(posedge clk);
    #1;
    run_op(~(b ^ c), b, c, 0, 0, 0, 18, "t6b");
    chk_v("t6b_value", 128'(bus.out_s1_o ^ bus.out_s2_o ^ bus.out_s3_o),
          128'(64'h1111111111111111));
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    chk_i("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prince_sbox_layer_driver.md
Name: prince_sbox_layer_driver

Overview:
Sequencer that feeds a full 64-bit, 3-share PRINCE state through one external 1-cycle-latency masked 4-bit S-box instance (inverse or forward), one nibble per cycle.
- Supplies the S-box with shares, fresh randomness and neighbour shares.
- Collects the 3-share outputs into a result buffer.
- Presents the full result on a valid/ready interface.
- Sits between the round datapath and the masked S-box, as the issuing/collecting end of the S-box share interface.

Parameters:
NIBBLES, 16, nibbles per state (state width = 4*NIBBLES)
SBOX_LAT, 1, S-box input-to-output latency in cycles (>=1)
R_WIDTH, 108, fresh-randomness bits per S-box evaluation

Ports:
clk  in  1  clock
rst_i  in  1  asynchronous active-high reset
in_valid_i  in  1  input state valid
in_ready_o  out  1  input state accepted when high with in_valid_i
in_s1_i / in_s2_i / in_s3_i  in  64 each  input shares
rnd_i  in  R_WIDTH  fresh randomness word
rnd_valid_i  in  1  rnd_i usable this cycle
rnd_ready_o  out  1  rnd_i consumed this cycle
sbox_in1_o / sbox_in2_o / sbox_in3_o  out  4 each  shares to S-box
sbox_r_o  out  R_WIDTH  randomness to S-box
sbox_nb_o  out  8  TwoSharesFromNeighbouringSbox
sbox_out1_i / sbox_out2_i / sbox_out3_i  in  4 each  S-box output shares
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when high with out_valid_o
out_s1_o / out_s2_o / out_s3_o  out  64 each  result shares
busy_o  out  1  state != IDLE

Behaviour:
Reset (rst_i high, async): state IDLE, counters 0, valid pipe cleared, all output registers 0; out_valid_o=0, rnd_ready_o=0, busy_o=0, sbox_*_o=0, in_ready_o=1 after release.
Reset mid-operation: in-flight nibbles and the partial result are discarded; no out_valid_o pulse.

FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready_o=1. On in_valid_i&in_ready_o edge: latch the three shares, issue_cnt=0, cap_cnt=0, go to RUN.
- RUN: issue strobe = rnd_valid_i.
  - rnd_ready_o = strobe, combinational.
  - On strobe: sbox_in{1,2,3}_o = nibble issue_cnt of the latched shares, bits [4k+3:4k], nibble 0 first.
  - sbox_r_o = rnd_i.
  - sbox_nb_o = {s2[k'], s1[k']} with k'=(issue_cnt+1) mod NIBBLES.
  - issue_cnt increments.
  - After issuing nibble NIBBLES-1, go to DRAIN.
- Without strobe: sbox_*_o hold their previous values and nothing enters the valid pipe (stall bubble).
- Valid pipe: a SBOX_LAT-deep shift register carrying strobe. When its tail is high at an edge, write sbox_out{1,2,3}_i into result nibble cap_cnt and increment cap_cnt. Capture continues in RUN and DRAIN, independent of stalls.
- DRAIN: when cap_cnt reaches NIBBLES, go to DONE; out_valid_o=1 from the next cycle.
- DONE: result registers stable and out_valid_o held until out_valid_o&out_ready_i, then go to IDLE.
  - in_ready_o=0 in RUN/DRAIN/DONE; no overlap between states.
  - Simultaneous out handshake and in_valid_i: input is not accepted that cycle (in_ready_o is 0 in DONE); accepted one cycle later.

Latency, rnd_valid_i constantly high, SBOX_LAT=1: accept edge E0, issues at cycles 1..16, last capture at E17, out_valid_o high in cycle 18. General latency: 2+NIBBLES+SBOX_LAT-1 + number of stall cycles.

Counters are $clog2(NIBBLES+1) bits wide; no wrap is reachable.

Decomposition:
- Shared package: FSM state enum, NIBBLE_W=4, default R_WIDTH, NB_W=8, nibble index function.
- One sub-module: prince_valid_pipe (SBOX_LAT-deep strobe shift register with async clear).
- The S-box itself stays external; the bench connects the masked inverse S-box.

Test Plan:
1. Plain 0x0123456789ABCDEF as s1, s2=s3=0, rnd_valid_i=1, out_ready_i=1 -> out_valid_o at cycle 18 after accept; s1^s2^s3 = 0xB732FD89A6405EC1 (inverse S-box).
2. Same plain with random s2/s3 and random rnd_i per cycle -> XOR of result shares = 0xB732FD89A6405EC1; rnd_ready_o pulses exactly 16 times.
3. rnd_valid_i low on issue cycles 3 and 9 -> 2 stall bubbles, out_valid_o at cycle 20, same unmasked result, sbox_nb_o for nibble 15 sourced from nibble 0.
4. out_ready_i low for 5 cycles in DONE -> out_valid_o and result stable, in_ready_o=0, second in_valid_i ignored until handshake.
5. rst_i asserted at issue cycle 7 -> outputs 0 immediately (async), no out_valid_o; a new input after release yields the correct result.
6. Back-to-back states 0x0000000000000000 and 0xFFFFFFFFFFFFFFFF -> unmasked results 0xBBBBBBBBBBBBBBBB then 0x1111111111111111.
